// File: rtl/fpga_operand_entry_pkg.sv
// Shared types for the ALU harness operand-entry front end.
// Entry FSM states, key roles and switch field positions live here.
package fpga_operand_entry_pkg;

  localparam int WORD_W_DEF = 32;

  typedef logic [WORD_W_DEF-1:0] word_t;
  typedef logic [3:0]            aluop_t;

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    ENTER_OP = 2'd2,
    SHOW     = 2'd3
  } entry_state_t;

  localparam int KEY_COMMIT  = 0;
  localparam int KEY_ABORT   = 1;
  localparam int SW_SIGN_BIT = 16;
  localparam int SW_EXT_BIT  = 17;

  function automatic logic [3:0] state_onehot(input entry_state_t s);
    logic [3:0] led;
    led = 4'b0001;
    case (s)
      ENTER_A:  led = 4'b0001;
      ENTER_B:  led = 4'b0010;
      ENTER_OP: led = 4'b0100;
      SHOW:     led = 4'b1000;
      default:  led = 4'b0001;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low pushbutton: 2-flop sync, stability counter, debounced level, press strobe.
// Latency: raw low at edge E -> press high after edge E+2+DEBOUNCE_CYCLES.
// No backpressure; press is a single-cycle strobe per accepted released->pressed change.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;
  logic          accept;

  // Accept the new level once the disagreement has persisted for the full window.
  assign accept = (sync_2 != level) && (cnt == CW'(DEBOUNCE_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= key;
      sync_2 <= sync_1;
      press  <= accept && !sync_2;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fpga_operand_entry.sv
// Board KEY/SW front end: synchronizes switches, debounces keys, walks A -> B -> OP -> SHOW entry.
// Latency: registered outputs update one edge after the debounced commit/abort strobe.
// No backpressure; abort overrides a same-cycle commit and nothing loads.
module fpga_operand_entry
  import fpga_operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int WORD_W          = 32,
  parameter int SW_W            = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [3:0]        KEY,
  input  logic [SW_W+1:0]   SW,
  output logic [WORD_W-1:0] porta,
  output logic [WORD_W-1:0] portb,
  output logic [3:0]        aluop,
  output logic              opvalid,
  output logic [3:0]        state_led,
  output logic [3:0]        key_pulse
);

  localparam int EXT_W = WORD_W - SW_W;

  logic [SW_W+1:0]   sw_sync_1;
  logic [SW_W+1:0]   sw_sync;
  logic [3:0]        key_level;
  logic [WORD_W-1:0] value;
  logic              ext_bit;

  entry_state_t state;
  entry_state_t state_nxt;
  logic         load_a;
  logic         load_b;
  logic         load_op;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk  (CLK),
      .rst_n(nRST),
      .key  (KEY[i]),
      .level(key_level[i]),
      .press(key_pulse[i])
    );
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sw_sync_1 <= '0;
      sw_sync   <= '0;
    end else begin
      sw_sync_1 <= SW;
      sw_sync   <= sw_sync_1;
    end
  end

  // Zero-extend unless extend mode is on and the sign switch is set.
  assign ext_bit = sw_sync[SW_EXT_BIT] & sw_sync[SW_SIGN_BIT];
  assign value   = {{EXT_W{ext_bit}}, sw_sync[SW_W-1:0]};

  always_comb begin
    state_nxt = state;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_op   = 1'b0;
    if (key_pulse[KEY_ABORT]) begin
      state_nxt = ENTER_A;
    end else if (key_pulse[KEY_COMMIT]) begin
      case (state)
        ENTER_A: begin
          state_nxt = ENTER_B;
          load_a    = 1'b1;
        end
        ENTER_B: begin
          state_nxt = ENTER_OP;
          load_b    = 1'b1;
        end
        ENTER_OP: begin
          state_nxt = SHOW;
          load_op   = 1'b1;
        end
        SHOW:    state_nxt = ENTER_A;
        default: state_nxt = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ENTER_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      porta     <= '0;
      portb     <= '0;
      aluop     <= '0;
      opvalid   <= 1'b0;
      state_led <= 4'b0001;
    end else begin
      if (load_a)  porta <= value;
      if (load_b)  portb <= value;
      if (load_op) aluop <= sw_sync[3:0];
      opvalid   <= (state_nxt == SHOW);
      state_led <= state_onehot(state_nxt);
    end
  end

  logic unused_levels;
  assign unused_levels = ^key_level;

endmodule

// File: tb/tb_fpga_operand_entry.sv
// Randomized self-checking bench for fpga_operand_entry with a short debounce window.
module tb_fpga_operand_entry;

  localparam int D = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [3:0]  KEY = 4'hF;
  logic [17:0] SW = '0;
  logic [31:0] porta;
  logic [31:0] portb;
  logic [3:0]  aluop;
  logic        opvalid;
  logic [3:0]  state_led;
  logic [3:0]  key_pulse;

  int total = 0;
  int bad = 0;

  // Reference model: entry step 0..3 = A, B, OP, SHOW.
  int          m_st = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [3:0]  m_op = '0;

  fpga_operand_entry #(
    .DEBOUNCE_CYCLES(D),
    .WORD_W(32),
    .SW_W(16)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .KEY(KEY),
    .SW(SW),
    .porta(porta),
    .portb(portb),
    .aluop(aluop),
    .opvalid(opvalid),
    .state_led(state_led),
    .key_pulse(key_pulse)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] operand_of(input logic [17:0] s);
    logic [31:0] v;
    v = 32'(s[15:0]);
    if (s[17] && s[16]) v = v + 32'hFFFF0000;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_sw(input logic [17:0] v);
    SW = v;
    repeat (3) tick();
  endtask

  // Holds the masked keys low for len sampled edges, records strobes, then applies the model.
  task automatic press(input logic [3:0] mask, input int len,
                       output int n_pulse, output int first_k, output logic [3:0] first_bits);
    n_pulse = 0;
    first_k = -1;
    first_bits = '0;
    KEY = ~mask;
    for (int k = 0; k < len + D + 8; k++) begin
      tick();
      if (k == len - 1) KEY = 4'hF;
      if (key_pulse != 4'h0) begin
        n_pulse += $countones(key_pulse);
        if (first_k < 0) begin
          first_k = k;
          first_bits = key_pulse;
        end
      end
    end
    if (len >= D + 1) begin
      if (mask[1]) begin
        m_st = 0;
      end else if (mask[0]) begin
        case (m_st)
          0: m_a = operand_of(SW);
          1: m_b = operand_of(SW);
          2: m_op = SW[3:0];
          default: ;
        endcase
        m_st = (m_st + 1) % 4;
      end
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    KEY = 4'hF;
    SW = '0;
    repeat (3) @(posedge CLK);
    #1;
    total++; if (state_led !== 4'b0001) begin bad++; $display("FAIL reset_led got %b want 0001", state_led); end
    total++; if ({porta, portb, aluop, opvalid, key_pulse} !== '0) begin bad++; $display("FAIL reset_outputs got %h %h %h %b %b want zeros", porta, portb, aluop, opvalid, key_pulse); end
    nRST = 1'b1;
    tick();
    m_st = 0; m_a = '0; m_b = '0; m_op = '0;
  endtask

  task automatic test_glitch();
    int n; int fk; logic [3:0] fb;
    press(4'b0001, 3, n, fk, fb);
    total++; if (n !== 0) begin bad++; $display("FAIL glitch_pulses got %0d want 0", n); end
    total++; if (state_led !== 4'b0001) begin bad++; $display("FAIL glitch_led got %b want 0001", state_led); end
  endtask

  task automatic test_single_press();
    int n; int fk; logic [3:0] fb;
    press(4'b0001, 10, n, fk, fb);
    total++; if (n !== 1) begin bad++; $display("FAIL single_count got %0d want 1", n); end
    total++; if (fk !== 2 + D) begin bad++; $display("FAIL single_latency got %0d want %0d", fk, 2 + D); end
    total++; if (fb !== 4'b0001) begin bad++; $display("FAIL single_bits got %b want 0001", fb); end
    total++; if (state_led !== 4'b0010) begin bad++; $display("FAIL single_led got %b want 0010", state_led); end
    press(4'b0010, 8, n, fk, fb);
    total++; if (state_led !== 4'b0001) begin bad++; $display("FAIL abort_led got %b want 0001", state_led); end
  endtask

  task automatic test_full_entry();
    int n; int fk; logic [3:0] fb;
    set_sw(18'h38001);
    press(4'b0001, 8, n, fk, fb);
    set_sw(18'h00005);
    press(4'b0001, 8, n, fk, fb);
    set_sw(18'h00002);
    press(4'b0001, 8, n, fk, fb);
    total++; if (porta !== 32'hFFFF8001) begin bad++; $display("FAIL entry_porta got %h want ffff8001", porta); end
    total++; if (portb !== 32'h00000005) begin bad++; $display("FAIL entry_portb got %h want 00000005", portb); end
    total++; if (aluop !== 4'h2) begin bad++; $display("FAIL entry_aluop got %h want 2", aluop); end
    total++; if (opvalid !== 1'b1) begin bad++; $display("FAIL entry_opvalid got %b want 1", opvalid); end
    total++; if (state_led !== 4'b1000) begin bad++; $display("FAIL entry_led got %b want 1000", state_led); end
  endtask

  task automatic test_show_commit();
    int n; int fk; logic [3:0] fb;
    set_sw(18'h2ABCD);
    press(4'b0001, 8, n, fk, fb);
    total++; if (state_led !== 4'b0001) begin bad++; $display("FAIL show_led got %b want 0001", state_led); end
    total++; if (opvalid !== 1'b0) begin bad++; $display("FAIL show_opvalid got %b want 0", opvalid); end
    total++; if ({porta, portb, aluop} !== {32'hFFFF8001, 32'h5, 4'h2}) begin bad++; $display("FAIL show_hold got %h %h %h want ffff8001 5 2", porta, portb, aluop); end
  endtask

  task automatic test_abort_race();
    int n; int fk; logic [3:0] fb;
    set_sw(18'h38001);
    press(4'b0001, 8, n, fk, fb);
    set_sw(18'h00005);
    press(4'b0001, 8, n, fk, fb);
    set_sw(18'h0000C);
    total++; if (state_led !== 4'b0100) begin bad++; $display("FAIL race_pre_led got %b want 0100", state_led); end
    press(4'b0011, 8, n, fk, fb);
    total++; if (fb !== 4'b0011) begin bad++; $display("FAIL race_bits got %b want 0011", fb); end
    total++; if (state_led !== 4'b0001) begin bad++; $display("FAIL race_led got %b want 0001", state_led); end
    total++; if (aluop !== m_op) begin bad++; $display("FAIL race_aluop got %h want %h", aluop, m_op); end
    total++; if (opvalid !== 1'b0) begin bad++; $display("FAIL race_opvalid got %b want 0", opvalid); end
  endtask

  task automatic test_switch_hold();
    int n; int fk; logic [3:0] fb;
    set_sw(18'h1234);
    press(4'b0001, 8, n, fk, fb);
    for (int i = 0; i < 30; i++) begin
      SW = 18'($urandom);
      tick();
      total++; if ({porta, portb, aluop} !== {m_a, m_b, m_op}) begin bad++; $display("FAIL hold_regs cycle %0d got %h %h %h want %h %h %h", i, porta, portb, aluop, m_a, m_b, m_op); end
    end
  endtask

  task automatic test_reset_mid();
    KEY = 4'b1110;
    repeat (3) tick();
    nRST = 1'b0;
    #1;
    total++; if ({porta, portb, aluop, opvalid, key_pulse} !== '0) begin bad++; $display("FAIL midreset_outputs got %h %h %h %b %b want zeros", porta, portb, aluop, opvalid, key_pulse); end
    total++; if (state_led !== 4'b0001) begin bad++; $display("FAIL midreset_led got %b want 0001", state_led); end
    KEY = 4'hF;
    repeat (3) tick();
    nRST = 1'b1;
    m_st = 0; m_a = '0; m_b = '0; m_op = '0;
    for (int k = 0; k < D + 8; k++) begin
      tick();
      total++; if (key_pulse !== 4'h0 || state_led !== 4'b0001) begin bad++; $display("FAIL midreset_lost cycle %0d got %b %b want 0000 0001", k, key_pulse, state_led); end
    end
  endtask

  task automatic test_random();
    logic [3:0] masks [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1000};
    int n; int fk; logic [3:0] fb; int len; logic [3:0] m; int want_n;
    for (int it = 0; it < 30; it++) begin
      set_sw(18'($urandom));
      m = masks[$urandom_range(0, 6)];
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : $urandom_range(6, 10);
      want_n = (len >= D + 1) ? $countones(m) : 0;
      press(m, len, n, fk, fb);
      total++; if (n !== want_n) begin bad++; $display("FAIL rand_pulses it %0d got %0d want %0d", it, n, want_n); end
      total++; if (state_led !== (4'b0001 << m_st)) begin bad++; $display("FAIL rand_led it %0d got %b want %b", it, state_led, 4'b0001 << m_st); end
      total++; if (opvalid !== (m_st == 3)) begin bad++; $display("FAIL rand_opvalid it %0d got %b want %b", it, opvalid, m_st == 3); end
      total++; if (porta !== m_a) begin bad++; $display("FAIL rand_porta it %0d got %h want %h", it, porta, m_a); end
      total++; if (portb !== m_b) begin bad++; $display("FAIL rand_portb it %0d got %h want %h", it, portb, m_b); end
      total++; if (aluop !== m_op) begin bad++; $display("FAIL rand_aluop it %0d got %h want %h", it, aluop, m_op); end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_single_press();
    test_full_entry();
    test_show_commit();
    test_abort_race();
    test_switch_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
